// File: rtl/gemm_sequencer.sv
// Operand staging and control for the GEMM systolic array: A/B buffers, skewed edge feed,
// drain wait, result snapshot and valid/ready streaming. Define GEMM_SEQ_PERF_EN for perf_cycles.
module gemm_sequencer #(
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DRAIN_CYC  = M + N,
    localparam int A_AW = (M * K > 1) ? $clog2(M * K) : 1,
    localparam int B_AW = (K * N > 1) ? $clog2(K * N) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic                      a_wr_en,
    input  logic [A_AW-1:0]           a_wr_addr,
    input  logic [DATA_WIDTH-1:0]     a_wr_data,
    input  logic                      b_wr_en,
    input  logic [B_AW-1:0]           b_wr_addr,
    input  logic [DATA_WIDTH-1:0]     b_wr_data,
    output logic                      arr_clr,
    output logic [M*DATA_WIDTH-1:0]   arr_a,
    output logic [N*DATA_WIDTH-1:0]   arr_b,
    input  logic [M*N*32-1:0]         arr_c,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [31:0]               res_data,
`ifdef GEMM_SEQ_PERF_EN
    output logic [31:0]               perf_cycles,
`endif
    output logic                      res_last
);

    localparam int FEED_LEN = K + ((M > N) ? M : N) - 1;
    localparam int MAX_FD   = (FEED_LEN > DRAIN_CYC) ? FEED_LEN : DRAIN_CYC;
    localparam int CNT_MAX  = (MAX_FD > M * N) ? MAX_FD : M * N;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int R_AW     = (M * N > 1) ? $clog2(M * N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_SNAP,
        S_OUTPUT
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            done_reg, done_next;
    logic            arr_clr_reg;

    // Every row/column reads its buffer in the same cycle, so the buffers stay in registers.
    logic [DATA_WIDTH-1:0] a_mem [M*K];
    logic [DATA_WIDTH-1:0] b_mem [K*N];
    logic [31:0]           res_mem [M*N];

    always_ff @(posedge clk) begin
        if (state_reg == S_IDLE) begin
            if (a_wr_en && int'(a_wr_addr) < M * K) a_mem[a_wr_addr] <= a_wr_data;
            if (b_wr_en && int'(b_wr_addr) < K * N) b_mem[b_wr_addr] <= b_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
            arr_clr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
            arr_clr_reg <= (state_reg == S_CLEAR);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                    cnt_next   = '0;
                end
            end
            S_CLEAR: begin
                state_next = S_FEED;
                cnt_next   = '0;
            end
            S_FEED: begin
                if (cnt_reg == CW'(FEED_LEN - 1)) begin
                    state_next = S_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_reg == CW'(DRAIN_CYC - 1)) begin
                    state_next = S_SNAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_SNAP: begin
                state_next = S_OUTPUT;
                cnt_next   = '0;
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    if (cnt_reg == CW'(M * N - 1)) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Row gi lags the feed step by gi cycles, which forms the west-edge wavefront.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            int                    k_pos;
            logic                  hit;
            logic [A_AW-1:0]       rd_addr;
            logic [DATA_WIDTH-1:0] a_q;
            assign k_pos   = int'(cnt_reg) - gi;
            assign hit     = (state_reg == S_FEED) && (k_pos >= 0) && (k_pos < K);
            assign rd_addr = A_AW'(gi * K + k_pos);
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) a_q <= '0;
                else          a_q <= hit ? a_mem[rd_addr] : '0;
            end
            assign arr_a[gi*DATA_WIDTH +: DATA_WIDTH] = a_q;
        end

        for (gi = 0; gi < N; gi++) begin : g_col
            int                    k_pos;
            logic                  hit;
            logic [B_AW-1:0]       rd_addr;
            logic [DATA_WIDTH-1:0] b_q;
            assign k_pos   = int'(cnt_reg) - gi;
            assign hit     = (state_reg == S_FEED) && (k_pos >= 0) && (k_pos < K);
            assign rd_addr = B_AW'(k_pos * N + gi);
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) b_q <= '0;
                else          b_q <= hit ? b_mem[rd_addr] : '0;
            end
            assign arr_b[gi*DATA_WIDTH +: DATA_WIDTH] = b_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (state_reg == S_SNAP) begin
            for (int i = 0; i < M * N; i++) res_mem[i] <= arr_c[i*32 +: 32];
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
    assign arr_clr   = arr_clr_reg;
    assign res_valid = (state_reg == S_OUTPUT);
    assign res_last  = res_valid && (cnt_reg == CW'(M * N - 1));
    assign res_data  = res_valid ? res_mem[R_AW'(cnt_reg)] : '0;

`ifdef GEMM_SEQ_PERF_EN
    logic [31:0] perf_reg;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_reg <= '0;
        end else if (state_reg == S_IDLE) begin
            if (start) perf_reg <= '0;
        end else if (perf_reg != 32'hFFFF_FFFF) begin
            perf_reg <= perf_reg + 32'd1;
        end
    end
    assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_gemm_sequencer.sv
// Self-checking bench for gemm_sequencer with a behavioural systolic-array model driving arr_c
// and a plain matrix-product reference for the streamed results.
module tb_gemm_sequencer;
    localparam int M = 4, K = 4, N = 4, DW = 8, FEED_LEN = 7, NW = M * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n, start, a_wr_en, b_wr_en, res_ready;
    logic [3:0]          a_wr_addr, b_wr_addr;
    logic [DW-1:0]       a_wr_data, b_wr_data;
    logic                busy, done, arr_clr, res_valid, res_last;
    logic [M*DW-1:0]     arr_a;
    logic [N*DW-1:0]     arr_b;
    logic [M*N*32-1:0]   arr_c;
    logic [31:0]         res_data;
`ifdef GEMM_SEQ_PERF_EN
    logic [31:0]         perf_cycles;
`endif

    gemm_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .arr_clr(arr_clr), .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef GEMM_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .res_last(res_last)
    );

    // Output-stationary array: PE(i,j) sees the west operand j cycles late and the north operand i cycles late.
    logic signed [DW-1:0] ha [M][N];
    logic signed [DW-1:0] hb [N][M];
    logic signed [31:0]   acc [M][N];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) begin
                    ha[i][j]  <= '0;
                    hb[j][i]  <= '0;
                    acc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) begin
                    automatic logic signed [DW-1:0] av = (j == 0) ? $signed(arr_a[i*DW +: DW]) : ha[i][j-1];
                    automatic logic signed [DW-1:0] bv = (i == 0) ? $signed(arr_b[j*DW +: DW]) : hb[j][i-1];
                    acc[i][j] <= arr_clr ? 32'sd0 : acc[i][j] + int'(av) * int'(bv);
                end
            for (int i = 0; i < M; i++) begin
                for (int d = N - 1; d > 0; d--) ha[i][d] <= ha[i][d-1];
                ha[i][0] <= $signed(arr_a[i*DW +: DW]);
            end
            for (int j = 0; j < N; j++) begin
                for (int d = M - 1; d > 0; d--) hb[j][d] <= hb[j][d-1];
                hb[j][0] <= $signed(arr_b[j*DW +: DW]);
            end
        end
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) arr_c[(i*N+j)*32 +: 32] = acc[i][j];
    end

    int a_ref [M*K];
    int b_ref [K*N];
    int exp_c [NW];
    int errors = 0;
    int checks = 0;

    typedef struct {
        int a_fill;
        int b_fill;
        int expect_word;
    } fill_vec_t;
    fill_vec_t fills [6];

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_arr_clr"}, arr_clr, 0);
        check({tag, "_arr_a"}, arr_a, 0);
        check({tag, "_arr_b"}, arr_b, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_last"}, res_last, 0);
        check({tag, "_res_data"}, res_data, 0);
    endtask

    task automatic load_buffers();
        for (int idx = 0; idx < NW; idx++) begin
            @(negedge clk);
            a_wr_en = 1'b1; a_wr_addr = 4'(idx); a_wr_data = 8'(a_ref[idx]);
            b_wr_en = 1'b1; b_wr_addr = 4'(idx); b_wr_data = 8'(b_ref[idx]);
        end
        @(negedge clk);
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic compute_expected();
        for (int r = 0; r < NW; r++) begin
            exp_c[r] = 0;
            for (int k = 0; k < K; k++) exp_c[r] += a_ref[(r / N) * K + k] * b_ref[k * N + (r % N)];
        end
    endtask

    // mode 0: plain run; 1: writes + start injected during FEED; 2: reset during DRAIN.
    // ready_mode 0: always ready; 1: pattern 1,0,0,1; 2: random.
    task automatic run_gemm(input string name, input int mode, input int ready_mode,
                            input bit fixed, input int fixed_val);
        int lat, w, p, t, busy_cnt, guard, ev;
        bit seen, rdy;
        compute_expected();
        if (fixed) for (int r = 0; r < NW; r++) exp_c[r] = fixed_val;
        busy_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat  = 1;
        seen = 1'b0;
        check({name, "_busy_after_start"}, busy, 1);
        while (lat < 60) begin
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            t = lat - 3;
            for (int i = 0; i < M; i++) begin
                ev = (t >= 0 && t < FEED_LEN && t - i >= 0 && t - i < K) ? a_ref[i*K + t - i] : 0;
                check({name, "_arr_a"}, $signed(arr_a[i*DW +: DW]), ev);
            end
            for (int j = 0; j < N; j++) begin
                ev = (t >= 0 && t < FEED_LEN && t - j >= 0 && t - j < K) ? b_ref[(t - j)*N + j] : 0;
                check({name, "_arr_b"}, $signed(arr_b[j*DW +: DW]), ev);
            end
            check({name, "_arr_clr"}, arr_clr, (lat == 2) ? 1 : 0);
            if (mode == 1 && lat == 4) begin
                a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 8'(a_ref[5] + 1);
                b_wr_en = 1'b1; b_wr_addr = 4'd3; b_wr_data = 8'(b_ref[3] - 1);
                start = 1'b1;
            end
            if (mode == 1 && lat == 5) begin
                a_wr_en = 1'b0; b_wr_en = 1'b0; start = 1'b0;
            end
            if (mode == 2 && lat == 12) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs({name, "_midreset"});
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                check_reset_outputs({name, "_postreset"});
                $display("run %s: aborted by reset at cycle %0d", name, lat);
                return;
            end
            busy_cnt += int'(busy);
            @(negedge clk);
            lat++;
        end
        check({name, "_first_valid_latency"}, lat, 18);
        if (!seen) return;
        w = 0; p = 0; guard = 0;
        while (w < NW && guard < 300) begin
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (p % 4 == 0) || (p % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            res_ready = rdy;
            busy_cnt += int'(busy);
            if (!res_valid) begin
                check({name, "_res_valid_high"}, res_valid, 1);
            end else begin
                check({name, "_res_data"}, $signed(res_data), exp_c[w]);
                check({name, "_res_last"}, res_last, (w == NW - 1) ? 1 : 0);
                if (rdy) w++;
            end
            p++;
            guard++;
            @(negedge clk);
        end
        res_ready = 1'b0;
        check({name, "_transfers"}, w, NW);
        check({name, "_done_pulse"}, done, 1);
        check({name, "_idle_after"}, busy, 0);
        check({name, "_valid_after"}, res_valid, 0);
`ifdef GEMM_SEQ_PERF_EN
        check({name, "_perf_cycles"}, perf_cycles, busy_cnt);
`endif
        @(negedge clk);
        check({name, "_done_single"}, done, 0);
        if (mode == 1) begin
            for (int c = 0; c < 3; c++) begin
                check({name, "_no_second_run"}, busy, 0);
                @(negedge clk);
            end
        end
        $display("run %s: words=%0d latency=%0d", name, w, lat);
    endtask

    task automatic randomize_ab();
        for (int idx = 0; idx < NW; idx++) begin
            a_ref[idx] = int'($urandom_range(0, 255)) - 128;
            b_ref[idx] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fills[0] = '{-128, -128, 65536};
        fills[1] = '{127, -128, -65024};
        fills[2] = '{127, 127, 64516};
        fills[3] = '{-1, 1, -4};
        fills[4] = '{0, -77, 0};
        fills[5] = '{3, -5, -60};

        reset_n = 1'b0; start = 1'b0; res_ready = 1'b0;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");

        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) a_ref[i*K + k] = (i == k) ? 1 : 0;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) b_ref[k*N + j] = k * 4 + j;
        load_buffers();
        run_gemm("identity", 0, 0, 1'b0, 0);

        for (int v = 0; v < 6; v++) begin
            for (int idx = 0; idx < NW; idx++) begin
                a_ref[idx] = fills[v].a_fill;
                b_ref[idx] = fills[v].b_fill;
            end
            load_buffers();
            run_gemm($sformatf("fill%0d", v), 0, 0, 1'b1, fills[v].expect_word);
        end

        randomize_ab();
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) a_ref[i*K + k] = 16 * i + k;
        load_buffers();
        run_gemm("skew", 0, 0, 1'b0, 0);

        randomize_ab();
        load_buffers();
        run_gemm("backpressure", 0, 1, 1'b0, 0);
        run_gemm("reuse_buffers", 0, 0, 1'b0, 0);

        randomize_ab();
        load_buffers();
        run_gemm("ignored_inputs", 1, 0, 1'b0, 0);

        run_gemm("reset_mid_drain", 2, 0, 1'b0, 0);
        randomize_ab();
        load_buffers();
        run_gemm("after_abort", 0, 0, 1'b0, 0);

        for (int n = 0; n < 4; n++) begin
            randomize_ab();
            load_buffers();
            run_gemm($sformatf("random%0d", n), 0, 2, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
